// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

    typedef enum logic [1:0] {
        HZ_RUN,
        HZ_STALL,
        HZ_FLUSH
    } hz_state_t;

    localparam logic [4:0] REG_X0 = 5'd0;

endpackage

// File: rtl/hazard_control_unit_sat_counter.sv
// Saturating up-counter used for the stall and flush performance counters.
module sat_counter #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != {CNT_W{1'b1}})) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/hazard_control_unit.sv
// Load-use stall and taken-branch flush controller for PC, IF/ID and ID/EX.
// Control outputs are Mealy so the pipeline registers act on the same edge.
module hazard_control_unit
    import hazard_pkg::*;
#(
    parameter int unsigned LOAD_USE_CYCLES = 1,
    parameter int unsigned FLUSH_CYCLES    = 1,
    parameter int unsigned CNT_W           = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    input  logic [4:0]       ex_rd,
    input  logic             ex_mem_read,
    input  logic             ex_branch_taken,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    localparam logic [2:0] LU_RELOAD = 3'(LOAD_USE_CYCLES - 1);
    localparam logic [2:0] FL_RELOAD = 3'(FLUSH_CYCLES - 1);

    hz_state_t  state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic       load_use;
    logic       flush_active;

    // x0 is hardwired, so a load targeting it can never create a dependency.
    assign load_use = ex_mem_read && (ex_rd != REG_X0) &&
                      ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
                       (id_uses_rs2 && (id_rs2 == ex_rd)));

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        flush_active = 1'b0;

        if (reset) begin
            state_d = HZ_RUN;
            cnt_d   = 3'd0;
        end else begin
            unique case (state_q)
                HZ_RUN: begin
                    // Branch wins: the dependent instruction is on the wrong path anyway.
                    if (ex_branch_taken) begin
                        if_id_flush  = 1'b1;
                        id_ex_flush  = 1'b1;
                        flush_active = 1'b1;
                        if (FLUSH_CYCLES > 1) begin
                            state_d = HZ_FLUSH;
                            cnt_d   = FL_RELOAD;
                        end
                    end else if (load_use) begin
                        pc_write    = 1'b0;
                        if_id_write = 1'b0;
                        id_ex_flush = 1'b1;
                        if (LOAD_USE_CYCLES > 1) begin
                            state_d = HZ_STALL;
                            cnt_d   = LU_RELOAD;
                        end
                    end
                end
                HZ_STALL: begin
                    pc_write    = 1'b0;
                    if_id_write = 1'b0;
                    id_ex_flush = 1'b1;
                    cnt_d       = cnt_q - 3'd1;
                    if (cnt_q == 3'd1) begin
                        state_d = HZ_RUN;
                    end
                end
                HZ_FLUSH: begin
                    if_id_flush  = 1'b1;
                    id_ex_flush  = 1'b1;
                    flush_active = 1'b1;
                    cnt_d        = cnt_q - 3'd1;
                    if (cnt_q == 3'd1) begin
                        state_d = HZ_RUN;
                    end
                end
                default: begin
                    state_d = HZ_RUN;
                    cnt_d   = 3'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= HZ_RUN;
            cnt_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clock (clock),
        .reset (reset),
        .inc   (!pc_write),
        .count (stall_count)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clock (clock),
        .reset (reset),
        .inc   (flush_active),
        .count (flush_count)
    );

endmodule

// File: tb/tb_hazard_control_unit.sv
// Directed bench for hazard_control_unit across three parameterisations sharing one input bus.
module tb_hazard_control_unit;

    logic       clock = 1'b0;
    logic       reset;
    logic [4:0] id_rs1, id_rs2, ex_rd;
    logic       id_uses_rs1, id_uses_rs2, ex_mem_read, ex_branch_taken;

    // a: 1/1/32, b: LU=2 FL=3, c: LU=3 FL=1 CNT_W=2
    logic        a_pc, a_ifw, a_iff, a_idf;
    logic [31:0] a_sc, a_fc;
    logic        b_pc, b_ifw, b_iff, b_idf;
    logic [31:0] b_sc, b_fc;
    logic        c_pc, c_ifw, c_iff, c_idf;
    logic [1:0]  c_sc, c_fc;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    hazard_control_unit #(.LOAD_USE_CYCLES(1), .FLUSH_CYCLES(1), .CNT_W(32)) dut_a (
        .clock(clock), .reset(reset), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .ex_rd(ex_rd),
        .ex_mem_read(ex_mem_read), .ex_branch_taken(ex_branch_taken),
        .pc_write(a_pc), .if_id_write(a_ifw), .if_id_flush(a_iff), .id_ex_flush(a_idf),
        .stall_count(a_sc), .flush_count(a_fc));

    hazard_control_unit #(.LOAD_USE_CYCLES(2), .FLUSH_CYCLES(3), .CNT_W(32)) dut_b (
        .clock(clock), .reset(reset), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .ex_rd(ex_rd),
        .ex_mem_read(ex_mem_read), .ex_branch_taken(ex_branch_taken),
        .pc_write(b_pc), .if_id_write(b_ifw), .if_id_flush(b_iff), .id_ex_flush(b_idf),
        .stall_count(b_sc), .flush_count(b_fc));

    hazard_control_unit #(.LOAD_USE_CYCLES(3), .FLUSH_CYCLES(1), .CNT_W(2)) dut_c (
        .clock(clock), .reset(reset), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .ex_rd(ex_rd),
        .ex_mem_read(ex_mem_read), .ex_branch_taken(ex_branch_taken),
        .pc_write(c_pc), .if_id_write(c_ifw), .if_id_flush(c_iff), .id_ex_flush(c_idf),
        .stall_count(c_sc), .flush_count(c_fc));

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic [4:0] rs1, input logic [4:0] rs2, input logic u1,
                         input logic u2, input logic [4:0] rd, input logic mr, input logic bt);
        id_rs1 = rs1; id_rs2 = rs2; id_uses_rs1 = u1; id_uses_rs2 = u2;
        ex_rd = rd; ex_mem_read = mr; ex_branch_taken = bt;
        #1;
    endtask

    task automatic idle();
        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    endtask

    task automatic lu_pulse();
        drive(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle();
        next_cycle();
        next_cycle();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        idle();
        next_cycle();
        // Reset state and defaults while reset is held, even with a hazard presented.
        lu_pulse();
        check_val("rst_pc_write", {31'd0, a_pc}, 32'd1);
        check_val("rst_id_ex_flush", {31'd0, a_idf}, 32'd0);
        next_cycle();
        reset = 1'b0;
        idle();
        check_val("rst_stall_cnt", a_sc, 32'd0);
        check_val("rst_flush_cnt", a_fc, 32'd0);

        // 1: single-cycle load-use stall
        do_reset();
        lu_pulse();
        check_val("t1_pc_write", {31'd0, a_pc}, 32'd0);
        check_val("t1_if_id_write", {31'd0, a_ifw}, 32'd0);
        check_val("t1_id_ex_flush", {31'd0, a_idf}, 32'd1);
        check_val("t1_if_id_flush", {31'd0, a_iff}, 32'd0);
        next_cycle();
        idle();
        check_val("t1_after_pc", {31'd0, a_pc}, 32'd1);
        check_val("t1_after_idf", {31'd0, a_idf}, 32'd0);
        check_val("t1_stall_cnt", a_sc, 32'd1);
        // same hazard via rs2
        drive(5'd0, 5'd9, 1'b0, 1'b1, 5'd9, 1'b1, 1'b0);
        check_val("t1_rs2_pc", {31'd0, a_pc}, 32'd0);
        next_cycle();
        idle();

        // 2: x0 and unused source never stall
        do_reset();
        drive(5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0);
        check_val("t2_x0_pc", {31'd0, a_pc}, 32'd1);
        next_cycle();
        drive(5'd0, 5'd7, 1'b0, 1'b0, 5'd7, 1'b1, 1'b0);
        check_val("t2_unused_pc", {31'd0, a_pc}, 32'd1);
        next_cycle();
        drive(5'd7, 5'd0, 1'b1, 1'b0, 5'd7, 1'b0, 1'b0);
        check_val("t2_nonload_pc", {31'd0, a_pc}, 32'd1);
        next_cycle();
        idle();
        check_val("t2_stall_cnt", a_sc, 32'd0);
        check_val("t2_flush_cnt", a_fc, 32'd0);

        // 3: LOAD_USE_CYCLES=2 holds the stall two cycles
        do_reset();
        lu_pulse();
        check_val("t3_c1_pc", {31'd0, b_pc}, 32'd0);
        next_cycle();
        idle();
        check_val("t3_c2_pc", {31'd0, b_pc}, 32'd0);
        check_val("t3_c2_ifw", {31'd0, b_ifw}, 32'd0);
        check_val("t3_c2_idf", {31'd0, b_idf}, 32'd1);
        next_cycle();
        check_val("t3_c3_pc", {31'd0, b_pc}, 32'd1);
        check_val("t3_c3_idf", {31'd0, b_idf}, 32'd0);
        check_val("t3_stall_cnt", b_sc, 32'd2);
        // back-to-back: hazard right after returning to RUN
        lu_pulse();
        check_val("t3_b2b_pc", {31'd0, b_pc}, 32'd0);
        next_cycle();
        idle();
        next_cycle();

        // 4: FLUSH_CYCLES=3, taken pulse in last flush cycle ignored
        do_reset();
        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
        check_val("t4_c1_iff", {31'd0, b_iff}, 32'd1);
        check_val("t4_c1_idf", {31'd0, b_idf}, 32'd1);
        check_val("t4_c1_pc", {31'd0, b_pc}, 32'd1);
        next_cycle();
        idle();
        check_val("t4_c2_iff", {31'd0, b_iff}, 32'd1);
        check_val("t4_c2_ifw", {31'd0, b_ifw}, 32'd1);
        next_cycle();
        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
        check_val("t4_c3_iff", {31'd0, b_iff}, 32'd1);
        check_val("t4_c3_pc", {31'd0, b_pc}, 32'd1);
        next_cycle();
        idle();
        check_val("t4_c4_iff", {31'd0, b_iff}, 32'd0);
        check_val("t4_c4_idf", {31'd0, b_idf}, 32'd0);
        check_val("t4_flush_cnt", b_fc, 32'd3);
        check_val("t4_stall_cnt", b_sc, 32'd0);

        // 5: branch and load-use together -> flush only
        do_reset();
        drive(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1);
        check_val("t5_pc", {31'd0, a_pc}, 32'd1);
        check_val("t5_ifw", {31'd0, a_ifw}, 32'd1);
        check_val("t5_iff", {31'd0, a_iff}, 32'd1);
        check_val("t5_idf", {31'd0, a_idf}, 32'd1);
        next_cycle();
        idle();
        check_val("t5_stall_cnt", a_sc, 32'd0);
        check_val("t5_flush_cnt", a_fc, 32'd1);

        // 6: reset mid-STALL, then saturation with CNT_W=2
        do_reset();
        lu_pulse();
        check_val("t6_c1_pc", {31'd0, c_pc}, 32'd0);
        next_cycle();
        idle();
        check_val("t6_c2_pc", {31'd0, c_pc}, 32'd0);
        reset = 1'b1;
        #1;
        check_val("t6_rst_pc", {31'd0, c_pc}, 32'd1);
        check_val("t6_rst_idf", {31'd0, c_idf}, 32'd0);
        next_cycle();
        reset = 1'b0;
        #1;
        check_val("t6_post_pc", {31'd0, c_pc}, 32'd1);
        check_val("t6_post_idf", {31'd0, c_idf}, 32'd0);
        check_val("t6_post_cnt", {30'd0, c_sc}, 32'd0);
        lu_pulse();
        next_cycle();
        idle();
        next_cycle();
        next_cycle();
        check_val("t6_cnt3", {30'd0, c_sc}, 32'd3);
        lu_pulse();
        check_val("t6_sat_pc", {31'd0, c_pc}, 32'd0);
        next_cycle();
        idle();
        check_val("t6_sat1", {30'd0, c_sc}, 32'd3);
        next_cycle();
        next_cycle();
        check_val("t6_sat3", {30'd0, c_sc}, 32'd3);
        check_val("t6_flush_cnt", {30'd0, c_fc}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
